// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit seven-segment scan controller.
// Blank gap, then one digit lit per slot from a latched snapshot.
module seg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic [3:0]  dig_en,
  output logic [7:0]  seg_cat,
  output logic [3:0]  seg_an,
  output logic        frame_tick
);

  localparam int MAXC =
    (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SLOT_CYCLES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      snap_nib_q, snap_nib_d;
  logic            snap_dp_q, snap_dp_d;
  logic            snap_en_q, snap_en_d;
  logic [3:0]      seg_an_q, seg_an_d;
  logic [7:0]      seg_cat_q, seg_cat_d;
  logic            tick_q, tick_d;

  logic [3:0]      cur_nib;
  logic            cur_dp;
  logic            cur_en;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    glyph = 7'h7F;
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'h7F;
    endcase
  endfunction

  // Digit source: live inputs on the entry edge, snapshot afterwards
  always_comb begin
    if (state_q == BLANK) begin
      cur_nib = digits[{idx_q, 2'b00} +: 4];
      cur_dp  = dp[idx_q];
      cur_en  = dig_en[idx_q];
    end else begin
      cur_nib = snap_nib_q;
      cur_dp  = snap_dp_q;
      cur_en  = snap_en_q;
    end
  end

  // Next-state, counter, snapshot and registered output decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CW'(1);
    snap_nib_d = snap_nib_q;
    snap_dp_d  = snap_dp_q;
    snap_en_d  = snap_en_q;
    seg_an_d   = 4'hF;
    seg_cat_d  = 8'hFF;
    tick_d     = 1'b0;
    if ((state_q == BLANK && cnt_q != B_LAST)
        || (state_q == SHOW && cnt_q == S_LAST)) begin
      seg_an_d  = 4'hF;
      seg_cat_d = 8'hFF;
    end else if (cur_en) begin
      seg_an_d  = ~(4'b0001 << idx_q);
      seg_cat_d = {~cur_dp, glyph(cur_nib)};
    end
    unique case (state_q)
      BLANK: begin
        if (cnt_q == B_LAST) begin
          state_d    = SHOW;
          cnt_d      = '0;
          snap_nib_d = cur_nib;
          snap_dp_d  = cur_dp;
          snap_en_d  = cur_en;
        end
      end
      SHOW: begin
        if (cnt_q == S_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          tick_d  = (idx_q == 2'd3);
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BLANK;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      snap_nib_q <= 4'h0;
      snap_dp_q  <= 1'b0;
      snap_en_q  <= 1'b0;
      seg_an_q   <= 4'hF;
      seg_cat_q  <= 8'hFF;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      snap_nib_q <= snap_nib_d;
      snap_dp_q  <= snap_dp_d;
      snap_en_q  <= snap_en_d;
      seg_an_q   <= seg_an_d;
      seg_cat_q  <= seg_cat_d;
      tick_q     <= tick_d;
    end
  end

  assign seg_an     = seg_an_q;
  assign seg_cat    = seg_cat_q;
  assign frame_tick = tick_q;

endmodule
